// File: rtl/alu_pkg.sv
// Shared ALU definitions: control encodings and datapath width used by the
// ALU and by anything that drives its operand/control bus.
package alu_pkg;

    localparam int XLEN       = 32;
    localparam int ALU_CTRL_W = 4;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_ctrl_t;

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Bundle of requester, ALU and response signals around the shared-ALU arbiter.
// Handshake: a transfer happens on a rising edge where valid && ready; ready may depend on valid.
interface alu_rr_arbiter_if
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int XLEN_P  = XLEN
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*XLEN_P-1:0]     req_op_a;
    logic [NUM_REQ*XLEN_P-1:0]     req_op_b;
    logic [NUM_REQ*ALU_CTRL_W-1:0] req_ctrl;

    logic [XLEN_P-1:0]             alu_op_a;
    logic [XLEN_P-1:0]             alu_op_b;
    logic [ALU_CTRL_W-1:0]         alu_ctrl;
    logic [XLEN_P-1:0]             alu_result;
    logic                          alu_zero;

    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    logic [XLEN_P-1:0]             rsp_result;
    logic                          rsp_zero;

    // Requesters, ALU and response consumer as seen from outside the arbiter.
    modport master (
        output req_valid, req_op_a, req_op_b, req_ctrl, alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_op_a, alu_op_b, alu_ctrl, rsp_valid, rsp_id, rsp_result, rsp_zero
    );

    modport slave (
        input  req_valid, req_op_a, req_op_b, req_ctrl, alu_result, alu_zero, rsp_ready,
        output req_ready, alu_op_a, alu_op_b, alu_ctrl, rsp_valid, rsp_id, rsp_result, rsp_zero
    );

endinterface

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set valid bit at or after ptr, wrapping to bit 0.
// Uses a thermometer mask with two lowest-set-bit priority stages.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [N-1:0] thermo;
    logic [N-1:0] masked;
    logic [N-1:0] pick_m;
    logic [N-1:0] pick_u;

    always_comb begin
        thermo = {N{1'b1}} << ptr;
        masked = valid & thermo;
        // x & -x isolates the lowest set bit.
        pick_m = masked & (~masked + N'(1));
        pick_u = valid & (~valid + N'(1));
        grant  = (|masked) ? pick_m : pick_u;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters, with a one-entry
// response register tagged by requester ID. Priority pointer is visible on dbg_rr_ptr.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int XLEN_P  = XLEN
) (
    input  logic                       clk,
    input  logic                       rst_n,
    alu_rr_arbiter_if.slave            bus,
    output logic [$clog2(NUM_REQ)-1:0] dbg_rr_ptr
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] pick_grant;
    logic [ID_W-1:0]    win;
    logic [NUM_REQ-1:0] grant;
    logic               can_accept;
    logic               accept;

    rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (win)
    );

    // The response slot frees and refills in one cycle, so draining counts as space.
    assign can_accept    = !bus.rsp_valid || bus.rsp_ready;
    assign grant         = pick_grant & {NUM_REQ{can_accept && rst_n}};
    assign accept        = |grant;
    assign bus.req_ready = grant;
    assign dbg_rr_ptr    = rr_ptr;

    always_comb begin
        bus.alu_op_a = '0;
        bus.alu_op_b = '0;
        bus.alu_ctrl = ALU_ADD;
        if (accept) begin
            bus.alu_op_a = bus.req_op_a[win*XLEN_P +: XLEN_P];
            bus.alu_op_b = bus.req_op_b[win*XLEN_P +: XLEN_P];
            bus.alu_ctrl = bus.req_ctrl[win*ALU_CTRL_W +: ALU_CTRL_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= '0;
            bus.rsp_result <= '0;
            bus.rsp_zero   <= 1'b0;
            rr_ptr         <= '0;
        end else if (accept) begin
            bus.rsp_valid  <= 1'b1;
            bus.rsp_id     <= win;
            bus.rsp_result <= bus.alu_result;
            bus.rsp_zero   <= bus.alu_zero;
            rr_ptr         <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end else if (bus.rsp_valid && bus.rsp_ready) begin
            bus.rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: stepped driver pushes hand-computed responses,
// a negedge monitor pops and compares each delivered response.
module tb_alu_rr_arbiter;
    import alu_pkg::*;

    localparam int N  = 4;
    localparam int XW = 32;
    localparam int IW = 2;
    localparam int EW = IW + 1 + XW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [IW-1:0] dbg_rr_ptr;

    alu_rr_arbiter_if #(.NUM_REQ(N), .XLEN_P(XW)) bus ();

    alu_rr_arbiter #(.NUM_REQ(N), .XLEN_P(XW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    always #5 clk = ~clk;

    // Per-requester payload and hand-computed results.
    logic [XW-1:0] op_a [N];
    logic [XW-1:0] op_b [N];
    logic [3:0]    ctl  [N];
    logic [XW-1:0] exp_res  [N];
    logic          exp_zero [N];

    logic [EW-1:0] exp_q [$];
    int n_tests = 0;
    int n_fail  = 0;

    always_comb begin
        bus.req_op_a = '0;
        bus.req_op_b = '0;
        bus.req_ctrl = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_op_a[i*XW +: XW] = op_a[i];
            bus.req_op_b[i*XW +: XW] = op_b[i];
            bus.req_ctrl[i*4 +: 4]   = ctl[i];
        end
    end

    // Environment ALU model.
    always_comb begin
        case (bus.alu_ctrl)
            ALU_ADD:  bus.alu_result = bus.alu_op_a + bus.alu_op_b;
            ALU_SUB:  bus.alu_result = bus.alu_op_a - bus.alu_op_b;
            ALU_SLL:  bus.alu_result = bus.alu_op_a << bus.alu_op_b[4:0];
            ALU_SLT:  bus.alu_result = {31'd0, $signed(bus.alu_op_a) < $signed(bus.alu_op_b)};
            ALU_SLTU: bus.alu_result = {31'd0, bus.alu_op_a < bus.alu_op_b};
            ALU_XOR:  bus.alu_result = bus.alu_op_a ^ bus.alu_op_b;
            ALU_SRL:  bus.alu_result = bus.alu_op_a >> bus.alu_op_b[4:0];
            ALU_SRA:  bus.alu_result = $unsigned($signed(bus.alu_op_a) >>> bus.alu_op_b[4:0]);
            ALU_OR:   bus.alu_result = bus.alu_op_a | bus.alu_op_b;
            ALU_AND:  bus.alu_result = bus.alu_op_a & bus.alu_op_b;
            default:  bus.alu_result = '0;
        endcase
        bus.alu_zero = (bus.alu_result == '0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs just after the edge, check grant at the negedge,
    // and queue the expected response for the requester that should win.
    task automatic step(input logic rst, input logic [N-1:0] valid, input logic rdy,
                        input logic [N-1:0] exp_ready);
        @(posedge clk);
        #1;
        rst_n         = rst;
        bus.req_valid = valid;
        bus.rsp_ready = rdy;
        @(negedge clk);
        check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        for (int i = 0; i < N; i++) begin
            if (exp_ready[i]) exp_q.push_back({IW'(i), exp_zero[i], exp_res[i]});
        end
    endtask

    // Monitor: every response transfer is compared against the head of the queue.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got id %0d result 0x%0h, expected no response",
                         bus.rsp_id, bus.rsp_result);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("rsp_id",     64'(bus.rsp_id),     64'(e[EW-1 -: IW]));
                check("rsp_zero",   64'(bus.rsp_zero),   64'(e[XW]));
                check("rsp_result", 64'(bus.rsp_result), 64'(e[XW-1:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        op_a[0] = 32'd1;          op_b[0] = 32'd2;  ctl[0] = ALU_ADD;
        op_a[1] = 32'd9;          op_b[1] = 32'd9;  ctl[1] = ALU_SUB;
        op_a[2] = 32'd5;          op_b[2] = 32'd7;  ctl[2] = ALU_ADD;
        op_a[3] = 32'h8000_0000;  op_b[3] = 32'd31; ctl[3] = ALU_SRA;
        exp_res[0] = 32'd3;          exp_zero[0] = 1'b0;
        exp_res[1] = 32'd0;          exp_zero[1] = 1'b1;
        exp_res[2] = 32'd12;         exp_zero[2] = 1'b0;
        exp_res[3] = 32'hFFFF_FFFF;  exp_zero[3] = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;

        // Reset held with every requester asking.
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 4'b1111, 1'b1, 4'b0000);
            check("rst_alu_op_a", 64'(bus.alu_op_a), 64'd0);
        end
        check("rst_rsp_valid",  64'(bus.rsp_valid),  64'd0);
        check("rst_rsp_id",     64'(bus.rsp_id),     64'd0);
        check("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
        check("rst_rsp_zero",   64'(bus.rsp_zero),   64'd0);
        check("rst_ptr",        64'(dbg_rr_ptr),     64'd0);

        // Release: full contention for 8 cycles, one response per cycle.
        step(1'b1, 4'b1111, 1'b1, 4'b0001);
        check("first_alu_op_a", 64'(bus.alu_op_a), 64'd1);
        step(1'b1, 4'b1111, 1'b1, 4'b0010);
        step(1'b1, 4'b1111, 1'b1, 4'b0100);
        step(1'b1, 4'b1111, 1'b1, 4'b1000);
        step(1'b1, 4'b1111, 1'b1, 4'b0001);
        step(1'b1, 4'b1111, 1'b1, 4'b0010);
        step(1'b1, 4'b1111, 1'b1, 4'b0100);
        step(1'b1, 4'b1111, 1'b1, 4'b1000);
        step(1'b1, 4'b0000, 1'b1, 4'b0000);
        check("idle_alu_op_b", 64'(bus.alu_op_b), 64'd0);
        step(1'b1, 4'b0000, 1'b1, 4'b0000);
        check("idle_ptr", 64'(dbg_rr_ptr), 64'd0);
        check("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);

        // Single request from requester 2.
        step(1'b1, 4'b0100, 1'b1, 4'b0100);
        check("single_alu_op_a", 64'(bus.alu_op_a), 64'd5);
        step(1'b1, 4'b0000, 1'b1, 4'b0000);
        check("single_ptr", 64'(dbg_rr_ptr), 64'd3);

        // Backpressure on a pending SRA response from requester 3.
        step(1'b1, 4'b1000, 1'b0, 4'b1000);
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 4'b1111, 1'b0, 4'b0000);
            check("bp_rsp_valid",  64'(bus.rsp_valid),  64'd1);
            check("bp_rsp_id",     64'(bus.rsp_id),     64'd3);
            check("bp_rsp_result", 64'(bus.rsp_result), 64'hFFFF_FFFF);
            check("bp_ptr",        64'(dbg_rr_ptr),     64'd0);
        end
        step(1'b1, 4'b1111, 1'b1, 4'b0001);
        step(1'b1, 4'b0100, 1'b1, 4'b0100);
        check("pre_skip_ptr", 64'(dbg_rr_ptr), 64'd1);

        // Pointer skip and wrap with requesters 0 and 2.
        step(1'b1, 4'b0101, 1'b1, 4'b0001);
        check("skip_ptr_before", 64'(dbg_rr_ptr), 64'd3);
        step(1'b1, 4'b0101, 1'b1, 4'b0100);
        check("wrap_ptr", 64'(dbg_rr_ptr), 64'd1);
        step(1'b1, 4'b0101, 1'b1, 4'b0001);

        // Reset with a response still pending: it must never be delivered.
        step(1'b0, 4'b1111, 1'b0, 4'b0000);
        check("mid_rsp_valid_pre", 64'(bus.rsp_valid), 64'd1);
        void'(exp_q.pop_back());
        step(1'b1, 4'b0000, 1'b1, 4'b0000);
        check("mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("mid_ptr",       64'(dbg_rr_ptr),    64'd0);
        step(1'b1, 4'b0000, 1'b1, 4'b0000);
        step(1'b1, 4'b0000, 1'b1, 4'b0000);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
